// File: rtl/ksa_pipe_adder.sv
// ksa_pipe_adder: pipelined Kogge-Stone add/sub, valid/ready, optional KSA_PIPE_OVF_EN overflow and USE_POWER_PINS pins
module ksa_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int LPS = 2
) (
`ifdef USE_POWER_PINS
  inout wire vdd,
  inout wire vss,
`endif
  input logic wb_clk_i,
  input logic wb_rst_i,
  input logic in_valid,
  output logic in_ready,
  input logic [WIDTH-1:0] a_i,
  input logic [WIDTH-1:0] b_i,
  input logic cin_i,
  input logic sub_i,
  output logic out_valid,
  input logic out_ready,
  output logic [WIDTH-1:0] sum_o,
  output logic cout_o,
  output logic ovf_o
);
  localparam int L = $clog2(WIDTH);
  localparam int NSTG = (L + LPS - 1) / LPS;
  logic [WIDTH-1:0] sg [0:NSTG];
  logic [WIDTH-1:0] sx [0:NSTG];
  logic [WIDTH-1:0] sp [0:NSTG-1];
  logic sc [0:NSTG];
  logic sv [0:NSTG];
  logic [WIDTH-1:0] cg [1:NSTG][0:LPS];
  logic [WIDTH-1:0] cp [1:NSTG][0:LPS];
  logic [WIDTH-1:0] bb, g0, p0;
  logic c0;
  assign in_ready = !out_valid || out_ready;
  assign bb = sub_i ? ~b_i : b_i;
  assign c0 = sub_i | cin_i;
  assign p0 = a_i ^ bb;
  assign g0 = (a_i & bb) | {{(WIDTH-1){1'b0}}, p0[0] & c0};
  // stage 0: operand conditioning, carry-in merged into bit 0 generate
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sv[0] <= 1'b0;
      sg[0] <= '0;
      sp[0] <= '0;
      sx[0] <= '0;
      sc[0] <= 1'b0;
    end else if (in_ready) begin
      sv[0] <= in_valid;
      sg[0] <= g0;
      sp[0] <= p0;
      sx[0] <= p0;
      sc[0] <= c0;
    end
  end
  genvar s, j;
  generate
    for (s = 1; s <= NSTG; s++) begin : g_stg
      assign cg[s][0] = sg[s-1];
      assign cp[s][0] = sp[s-1];
      for (j = 1; j <= LPS; j++) begin : g_lvl
        if ((s - 1) * LPS + j - 1 < L) begin : g_pre
          localparam int D = 1 << ((s - 1) * LPS + j - 1);
          assign cg[s][j] = cg[s][j-1] | (cp[s][j-1] & (cg[s][j-1] << D));
          assign cp[s][j] = cp[s][j-1] & ((cp[s][j-1] << D) | ~({WIDTH{1'b1}} << D));
        end else begin : g_pass
          assign cg[s][j] = cg[s][j-1];
          assign cp[s][j] = cp[s][j-1];
        end
      end
      // stage register after this group of prefix levels; whole pipe stalls together
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
          sv[s] <= 1'b0;
          sg[s] <= '0;
          sx[s] <= '0;
          sc[s] <= 1'b0;
        end else if (in_ready) begin
          sv[s] <= sv[s-1];
          sg[s] <= cg[s][LPS];
          sx[s] <= sx[s-1];
          sc[s] <= sc[s-1];
        end
      end
      if (s < NSTG) begin : g_p
        // group propagate only needed while prefix levels remain
        always_ff @(posedge wb_clk_i) begin
          if (wb_rst_i) sp[s] <= '0;
          else if (in_ready) sp[s] <= cp[s][LPS];
        end
      end
    end
  endgenerate
  assign out_valid = sv[NSTG];
  assign sum_o = sx[NSTG] ^ {sg[NSTG][WIDTH-2:0], sc[NSTG]};
  assign cout_o = sg[NSTG][WIDTH-1];
`ifdef KSA_PIPE_OVF_EN
  assign ovf_o = sg[NSTG][WIDTH-1] ^ sg[NSTG][WIDTH-2];
`else
  assign ovf_o = 1'b0;
`endif
endmodule
